// File: rtl/ca_engine_param_if.sv
// Control/status bundle between the board switch interface and the CA engine.
// Handshake: load/step are single-cycle pulses sampled on posedge clk; gen_valid
// marks the one cycle in which state_out holds a new generation; no backpressure.
interface ca_engine_param_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [7:0]       rule_in;
  logic [1:0]       bound_mode;
  logic             run;
  logic             step;
  logic [WIDTH-1:0] state_out;
  logic [CNT_W-1:0] gen_count;
  logic             gen_valid;
  logic             loaded;
  logic             stalled;
  logic             extinct;
  logic             dbg_ready;

  modport master (
    output load, seed, rule_in, bound_mode, run, step,
    input  state_out, gen_count, gen_valid, loaded, stalled, extinct, dbg_ready
  );

  modport slave (
    input  load, seed, rule_in, bound_mode, run, step,
    output state_out, gen_count, gen_valid, loaded, stalled, extinct, dbg_ready
  );
endinterface

// File: rtl/ca_engine_param.sv
// Parametrised 1D elementary cellular automaton with programmable rule, boundary
// mode, run/step control, rate divider, saturating generation counter and status.
module ca_engine_param #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 1,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  ca_engine_param_if.slave bus
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {S_EMPTY, S_READY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cells_q, cells_d;
  logic [7:0]       rule_q, rule_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;

  logic [WIDTH-1:0] next_cells;
  logic [WIDTH+1:0] ext;
  logic             left_nb, right_nb;
  logic             ready, tick, advance;

  // ext[0] is the virtual cell left of cell 0, ext[WIDTH+1] the one right of WIDTH-1.
  always_comb begin
    left_nb  = 1'b0;
    right_nb = 1'b0;
    case (mode_q)
      2'b00: begin left_nb = cells_q[WIDTH-1]; right_nb = cells_q[0];       end
      2'b01: begin left_nb = 1'b0;             right_nb = 1'b0;             end
      2'b10: begin left_nb = 1'b1;             right_nb = 1'b1;             end
      default: begin left_nb = cells_q[0];     right_nb = cells_q[WIDTH-1]; end
    endcase
    ext        = {right_nb, cells_q, left_nb};
    next_cells = '0;
    for (int i = 0; i < WIDTH; i++) begin
      next_cells[i] = rule_q[{ext[i], ext[i+1], ext[i+2]}];
    end
  end

  always_comb begin
    state_d   = state_q;
    cells_d   = cells_q;
    rule_d    = rule_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;

    ready   = (state_q == S_READY);
    tick    = (div_q == DIV_LAST);
    advance = ready && !bus.load &&
              ((bus.run && tick) || (!bus.run && bus.step));

    // Divider only runs while auto-advancing; any pause restarts a full period.
    if (ready && bus.run && !bus.load) div_d = tick ? '0 : div_q + DIV_W'(1);
    else                               div_d = '0;

    if (bus.load) begin
      state_d   = S_READY;
      cells_d   = bus.seed;
      rule_d    = bus.rule_in;
      mode_d    = bus.bound_mode;
      cnt_d     = '0;
      stalled_d = 1'b0;
    end else if (advance) begin
      cells_d   = next_cells;
      valid_d   = 1'b1;
      stalled_d = (next_cells == cells_q);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      cells_q   <= '0;
      rule_q    <= 8'h1E;
      mode_q    <= 2'b00;
      cnt_q     <= '0;
      div_q     <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cells_q   <= cells_d;
      rule_q    <= rule_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  assign bus.state_out = cells_q;
  assign bus.gen_count = cnt_q;
  assign bus.gen_valid = valid_q;
  assign bus.loaded    = (state_q == S_READY);
  assign bus.stalled   = stalled_q;
  assign bus.extinct   = ~|cells_q;
  assign bus.dbg_ready = (state_q == S_READY);
endmodule

// File: tb/tb_ca_engine_param.sv
// Bench for ca_engine_param: random run/step/load traffic against a rule-level
// model, plus directed boundary, divider, saturation and async-reset cases.
module tb_ca_engine_param;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [W-1:0] exp_q[$];

  ca_engine_param_if #(.WIDTH(W), .CNT_W(16)) bus_a ();
  ca_engine_param_if #(.WIDTH(W), .CNT_W(4))  bus_b ();

  ca_engine_param #(.WIDTH(W), .TICK_DIV(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  ca_engine_param #(.WIDTH(W), .TICK_DIV(4), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: next generation straight from the neighbourhood rule.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] s, input logic [7:0] r,
                                            input logic [1:0] m);
    logic [W-1:0] n;
    int l, c, rt;
    n = '0;
    for (int i = 0; i < W; i++) begin
      c = int'(s[i]);
      if (i == 0) begin
        case (m)
          2'd0: l = int'(s[W-1]);
          2'd1: l = 0;
          2'd2: l = 1;
          default: l = int'(s[0]);
        endcase
      end else l = int'(s[i-1]);
      if (i == W-1) begin
        case (m)
          2'd0: rt = int'(s[0]);
          2'd1: rt = 0;
          2'd2: rt = 1;
          default: rt = int'(s[W-1]);
        endcase
      end else rt = int'(s[i+1]);
      n[i] = r[l*4 + c*2 + rt];
    end
    return n;
  endfunction

  // driver tasks for instance A
  task automatic idle_a();
    bus_a.load = 0; bus_a.step = 0; bus_a.run = 0;
  endtask

  task automatic load_a(input logic [W-1:0] s, input logic [7:0] r, input logic [1:0] m);
    bus_a.load = 1; bus_a.seed = s; bus_a.rule_in = r; bus_a.bound_mode = m;
    tick();
    bus_a.load = 0;
  endtask

  task automatic step_a();
    bus_a.step = 1;
    tick();
    bus_a.step = 0;
  endtask

  task automatic load_b(input logic [W-1:0] s, input logic [7:0] r, input logic [1:0] m);
    bus_b.load = 1; bus_b.seed = s; bus_b.rule_in = r; bus_b.bound_mode = m;
    tick();
    bus_b.load = 0;
  endtask

  // model state for the random phase
  logic [W-1:0] m_state;
  logic [7:0]   m_rule;
  logic [1:0]   m_mode;
  logic [15:0]  m_cnt;
  logic         m_loaded, m_stalled, m_valid;

  initial begin
    int pulses, last_pulse, gap_bad;
    logic [W-1:0] e;
    n_checks = 0;
    n_fail   = 0;
    rst = 1;
    idle_a();
    bus_a.seed = '0; bus_a.rule_in = '0; bus_a.bound_mode = '0;
    bus_b.load = 0; bus_b.step = 0; bus_b.run = 0;
    bus_b.seed = '0; bus_b.rule_in = '0; bus_b.bound_mode = '0;
    repeat (3) tick();
    rst = 0;
    tick();

    check("rst_state", bus_a.state_out, 0);
    check("rst_count", bus_a.gen_count, 0);
    check("rst_loaded", bus_a.loaded, 0);
    check("rst_valid", bus_a.gen_valid, 0);
    check("rst_extinct", bus_a.extinct, 1);

    // step before any load is ignored
    step_a();
    check("preload_step_state", bus_a.state_out, 0);
    check("preload_step_loaded", bus_a.loaded, 0);
    check("preload_step_valid", bus_a.gen_valid, 0);

    // random phase on A (tick every cycle)
    m_state = '0; m_rule = 8'h1E; m_mode = 0; m_cnt = 0;
    m_loaded = 0; m_stalled = 0; m_valid = 0;
    for (int k = 0; k < 400; k++) begin
      bus_a.load       = ($urandom_range(0, 9) == 0);
      bus_a.seed       = W'($urandom);
      bus_a.rule_in    = 8'($urandom);
      bus_a.bound_mode = 2'($urandom_range(0, 3));
      bus_a.run        = ($urandom_range(0, 3) == 0);
      bus_a.step       = ($urandom_range(0, 1) == 1);
      if (bus_a.load) begin
        m_state = bus_a.seed; m_rule = bus_a.rule_in; m_mode = bus_a.bound_mode;
        m_cnt = 0; m_stalled = 0; m_loaded = 1; m_valid = 0;
      end else if (m_loaded && (bus_a.run || bus_a.step)) begin
        e = ref_next(m_state, m_rule, m_mode);
        m_stalled = (e == m_state);
        m_state = e;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        m_valid = 1;
        exp_q.push_back(e);
      end else m_valid = 0;
      tick();
      check("rnd_state", bus_a.state_out, m_state);
      check("rnd_count", bus_a.gen_count, m_cnt);
      check("rnd_valid", bus_a.gen_valid, m_valid);
      check("rnd_stalled", bus_a.stalled, m_stalled);
      check("rnd_loaded", bus_a.loaded, m_loaded);
      check("rnd_extinct", bus_a.extinct, (m_state == 0));
      if (bus_a.gen_valid) begin
        if (exp_q.size() > 0) check("sb_gen", bus_a.state_out, exp_q.pop_front());
        else check("sb_unexpected_gen", 1, 0);
      end
    end
    idle_a();
    check("sb_leftover", exp_q.size(), 0);
    tick();

    // directed rule / boundary cases
    load_a(8'h08, 8'h1E, 2'b00);
    check("r30_load_state", bus_a.state_out, 8'h08);
    check("r30_load_count", bus_a.gen_count, 0);
    check("r30_load_valid", bus_a.gen_valid, 0);
    step_a();
    check("r30_step_state", bus_a.state_out, 8'h1C);
    check("r30_step_valid", bus_a.gen_valid, 1);
    check("r30_step_count", bus_a.gen_count, 1);
    tick();
    check("r30_valid_drop", bus_a.gen_valid, 0);

    load_a(8'h01, 8'h5A, 2'b01); step_a();
    check("r90_fixed0", bus_a.state_out, 8'h02);
    load_a(8'h01, 8'h5A, 2'b00); step_a();
    check("r90_wrap", bus_a.state_out, 8'h82);
    load_a(8'h01, 8'h5A, 2'b10); step_a();
    check("r90_fixed1", bus_a.state_out, 8'h83);
    load_a(8'h01, 8'h5A, 2'b11); step_a();
    check("r90_reflect", bus_a.state_out, ref_next(8'h01, 8'h5A, 2'b11));

    // bound_mode changes after load have no effect
    load_a(8'h01, 8'h5A, 2'b01);
    bus_a.bound_mode = 2'b10;
    step_a();
    check("mode_latched", bus_a.state_out, 8'h02);

    load_a(8'hA5, 8'hCC, 2'b00); step_a();
    check("identity_state", bus_a.state_out, 8'hA5);
    check("identity_stalled", bus_a.stalled, 1);
    load_a(8'hA5, 8'h00, 2'b00);
    check("reload_clears_stalled", bus_a.stalled, 0);
    step_a();
    check("r0_state", bus_a.state_out, 8'h00);
    check("r0_extinct", bus_a.extinct, 1);
    check("r0_stalled", bus_a.stalled, 0);

    // load and step in the same cycle: load wins
    step_a();
    bus_a.load = 1; bus_a.step = 1; bus_a.seed = 8'h3C; bus_a.rule_in = 8'h1E;
    bus_a.bound_mode = 2'b00;
    tick();
    idle_a();
    check("load_step_state", bus_a.state_out, 8'h3C);
    check("load_step_count", bus_a.gen_count, 0);
    check("load_step_valid", bus_a.gen_valid, 0);

    // divider on B: 20 cycles of run -> 5 pulses, 4 apart
    load_b(8'h08, 8'h1E, 2'b00);
    bus_b.run = 1;
    pulses = 0; last_pulse = -1; gap_bad = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus_b.gen_valid) begin
        if (last_pulse >= 0 && c - last_pulse != 4) gap_bad++;
        if (last_pulse < 0 && c != 4) gap_bad++;
        last_pulse = c;
        pulses++;
      end
    end
    bus_b.run = 0;
    check("div_pulses", pulses, 5);
    check("div_spacing", gap_bad, 0);
    check("div_count", bus_b.gen_count, 5);

    // run dropped at cycle 10
    load_b(8'h08, 8'h1E, 2'b00);
    bus_b.run = 1;
    pulses = 0;
    repeat (10) begin tick(); if (bus_b.gen_valid) pulses++; end
    bus_b.run = 0;
    check("div_first10", pulses, 2);
    pulses = 0;
    repeat (10) begin tick(); if (bus_b.gen_valid) pulses++; end
    check("div_after_stop", pulses, 0);
    check("div_stop_state", bus_b.state_out,
          ref_next(ref_next(8'h08, 8'h1E, 2'b00), 8'h1E, 2'b00));

    // step ignored while run=1; divider restarts a full period
    load_b(8'h08, 8'h1E, 2'b00);
    bus_b.run = 1; bus_b.step = 1;
    pulses = 0;
    repeat (3) begin tick(); if (bus_b.gen_valid) pulses++; end
    bus_b.run = 0; bus_b.step = 0;
    check("step_while_run", pulses, 0);
    check("step_while_run_count", bus_b.gen_count, 0);

    // saturation: CNT_W=4, 20 held steps
    load_b(8'h5A, 8'h96, 2'b11);
    bus_b.step = 1;
    pulses = 0;
    repeat (20) begin tick(); if (bus_b.gen_valid) pulses++; end
    bus_b.step = 0;
    check("sat_pulses", pulses, 20);
    check("sat_count", bus_b.gen_count, 15);

    // asynchronous reset mid-run, between clock edges
    load_a(8'h08, 8'h1E, 2'b00);
    bus_a.run = 1;
    repeat (3) tick();
    #2 rst = 1;
    #1;
    check("arst_state", bus_a.state_out, 0);
    check("arst_count", bus_a.gen_count, 0);
    check("arst_valid", bus_a.gen_valid, 0);
    check("arst_loaded", bus_a.loaded, 0);
    check("arst_stalled", bus_a.stalled, 0);
    check("arst_extinct", bus_a.extinct, 1);
    check("arst_b_count", bus_b.gen_count, 0);
    #3 rst = 0;
    bus_a.run = 0;
    tick();
    bus_a.step = 1;
    repeat (3) tick();
    bus_a.step = 0;
    check("post_rst_state", bus_a.state_out, 0);
    check("post_rst_loaded", bus_a.loaded, 0);
    check("post_rst_count", bus_a.gen_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
